// File: rtl/sram.sv
// Synchronous single-port SRAM with active-low enables, registered read data
// and a small IDLE/WRITE/READ access-tracking FSM.
module sram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chip_enable_n,
  input  logic                  write_enable_n,
  input  logic                  read_enable_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t current_state;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic wr_req;
  logic rd_req;
  logic in_range;

  always_comb begin
    wr_req   = !chip_enable_n && !write_enable_n;
    rd_req   = !chip_enable_n &&  write_enable_n && !read_enable_n;
    in_range = (int'(address) < MEM_SIZE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      current_state <= IDLE;
      data_out      <= '0;
    end else begin
      if (wr_req) begin
        current_state <= WRITE;
      end else if (rd_req) begin
        current_state <= READ;
        data_out      <= in_range ? mem[address] : '0;
      end else begin
        current_state <= IDLE;
      end
    end
  end

  // Storage sits outside the reset domain so contents survive reset; the
  // reset_n term still suppresses a write on an edge where reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && wr_req && in_range) begin
      mem[address] <= data_in;
    end
  end

endmodule

// File: tb/tb_sram.sv
// Directed self-checking bench for sram: reset, write, read, back-to-back,
// write priority, chip-disable and reset-during-access scenarios.
module tb_sram;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic       clk;
  logic       reset_n;
  logic       chip_enable_n;
  logic       write_enable_n;
  logic       read_enable_n;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int tests;
  int fails;

  sram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_SIZE(256)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .chip_enable_n  (chip_enable_n),
    .write_enable_n (write_enable_n),
    .read_enable_n  (read_enable_n),
    .address        (address),
    .data_in        (data_in),
    .data_out       (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string sname(input logic [1:0] s);
    case (s)
      S_IDLE:  return "IDLE";
      S_WRITE: return "WRITE";
      S_READ:  return "READ";
      default: return "UNKNOWN";
    endcase
  endfunction

  function automatic logic [1:0] cur_state();
    logic [1:0] s;
    s = dut.current_state;
    return s;
  endfunction

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chip_enable_n  = 1'b1;
    write_enable_n = 1'b1;
    read_enable_n  = 1'b1;
  endtask

  task automatic drive_write(input logic [7:0] a, input logic [7:0] d);
    chip_enable_n  = 1'b0;
    write_enable_n = 1'b0;
    read_enable_n  = 1'b1;
    address        = a;
    data_in        = d;
  endtask

  task automatic drive_read(input logic [7:0] a);
    chip_enable_n  = 1'b0;
    write_enable_n = 1'b1;
    read_enable_n  = 1'b0;
    address        = a;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_idle();
    address = '0;
    data_in = '0;
    #1;
    tests++;
    if (data_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_async_dout: got %h expected %h", data_out, 8'h00);
    end
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    tests++;
    if (cur_state() !== S_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %s expected %s", sname(cur_state()), sname(S_IDLE));
    end
    tests++;
    if (data_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_dout: got %h expected %h", data_out, 8'h00);
    end
  endtask

  task automatic test_write();
    drive_write(8'h00, 8'hAA);
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests++;
      if (cur_state() !== S_WRITE) begin
        fails++;
        $display("FAIL write_state_%0d: got %s expected %s", i, sname(cur_state()), sname(S_WRITE));
      end
    end
    bus_idle();
    cycle();
    tests++;
    if (cur_state() !== S_IDLE) begin
      fails++;
      $display("FAIL write_to_idle: got %s expected %s", sname(cur_state()), sname(S_IDLE));
    end
    tests++;
    if (dut.mem[0] !== 8'hAA) begin
      fails++;
      $display("FAIL write_mem0: got %h expected %h", dut.mem[0], 8'hAA);
    end
    tests++;
    if (data_out !== 8'h00) begin
      fails++;
      $display("FAIL write_dout_held: got %h expected %h", data_out, 8'h00);
    end
  endtask

  task automatic test_read();
    drive_read(8'h00);
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests++;
      if (data_out !== 8'hAA) begin
        fails++;
        $display("FAIL read_dout_%0d: got %h expected %h", i, data_out, 8'hAA);
      end
      tests++;
      if (cur_state() !== S_READ) begin
        fails++;
        $display("FAIL read_state_%0d: got %s expected %s", i, sname(cur_state()), sname(S_READ));
      end
    end
    bus_idle();
    cycle();
  endtask

  task automatic test_back_to_back();
    drive_write(8'hFF, 8'h55);
    cycle();
    drive_write(8'h01, 8'h11);
    cycle();
    drive_read(8'hFF);
    cycle();
    tests++;
    if (data_out !== 8'h55) begin
      fails++;
      $display("FAIL b2b_read_ff: got %h expected %h", data_out, 8'h55);
    end
    drive_read(8'h01);
    cycle();
    tests++;
    if (data_out !== 8'h11) begin
      fails++;
      $display("FAIL b2b_read_01: got %h expected %h", data_out, 8'h11);
    end
    bus_idle();
    cycle();
    cycle();
    tests++;
    if (data_out !== 8'h11) begin
      fails++;
      $display("FAIL b2b_idle_hold: got %h expected %h", data_out, 8'h11);
    end
    tests++;
    if (cur_state() !== S_IDLE) begin
      fails++;
      $display("FAIL b2b_idle_state: got %s expected %s", sname(cur_state()), sname(S_IDLE));
    end
  endtask

  task automatic test_priority();
    chip_enable_n  = 1'b0;
    write_enable_n = 1'b0;
    read_enable_n  = 1'b0;
    address        = 8'h10;
    data_in        = 8'h3C;
    cycle();
    tests++;
    if (cur_state() !== S_WRITE) begin
      fails++;
      $display("FAIL prio_state: got %s expected %s", sname(cur_state()), sname(S_WRITE));
    end
    tests++;
    if (data_out !== 8'h11) begin
      fails++;
      $display("FAIL prio_dout_held: got %h expected %h", data_out, 8'h11);
    end
    tests++;
    if (dut.mem[8'h10] !== 8'h3C) begin
      fails++;
      $display("FAIL prio_mem10: got %h expected %h", dut.mem[8'h10], 8'h3C);
    end
    drive_read(8'h10);
    cycle();
    tests++;
    if (data_out !== 8'h3C) begin
      fails++;
      $display("FAIL prio_readback: got %h expected %h", data_out, 8'h3C);
    end
    bus_idle();
    cycle();
  endtask

  task automatic test_chip_disable();
    chip_enable_n  = 1'b1;
    write_enable_n = 1'b0;
    read_enable_n  = 1'b0;
    address        = 8'h00;
    data_in        = 8'h77;
    cycle();
    cycle();
    tests++;
    if (dut.mem[0] !== 8'hAA) begin
      fails++;
      $display("FAIL ce_mem0: got %h expected %h", dut.mem[0], 8'hAA);
    end
    tests++;
    if (cur_state() !== S_IDLE) begin
      fails++;
      $display("FAIL ce_state: got %s expected %s", sname(cur_state()), sname(S_IDLE));
    end
    tests++;
    if (data_out !== 8'h3C) begin
      fails++;
      $display("FAIL ce_dout_held: got %h expected %h", data_out, 8'h3C);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid_access();
    drive_read(8'h01);
    cycle();
    tests++;
    if (data_out !== 8'h11) begin
      fails++;
      $display("FAIL rst_pre_read: got %h expected %h", data_out, 8'h11);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (data_out !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_dout: got %h expected %h", data_out, 8'h00);
    end
    tests++;
    if (cur_state() !== S_IDLE) begin
      fails++;
      $display("FAIL rst_mid_state: got %s expected %s", sname(cur_state()), sname(S_IDLE));
    end
    // A write held across an edge while in reset must be dropped.
    drive_write(8'h00, 8'h99);
    cycle();
    reset_n = 1'b1;
    bus_idle();
    cycle();
    tests++;
    if (dut.mem[0] !== 8'hAA) begin
      fails++;
      $display("FAIL rst_mem0_kept: got %h expected %h", dut.mem[0], 8'hAA);
    end
    tests++;
    if (data_out !== 8'h00) begin
      fails++;
      $display("FAIL rst_post_dout: got %h expected %h", data_out, 8'h00);
    end
    drive_read(8'h00);
    cycle();
    tests++;
    if (data_out !== 8'hAA) begin
      fails++;
      $display("FAIL rst_post_read: got %h expected %h", data_out, 8'hAA);
    end
    bus_idle();
    cycle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_priority();
    test_chip_disable();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
